// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: 8N1 serial byte receiver with a ready/acknowledge handshake,
// sticky overrun flag and single-cycle framing-error pulse.
module uart_cmd_rx #(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy,
    output logic       ovr,
    output logic       frm_err,
    output logic       busy
);

    localparam int CNT_W = $clog2(BAUD_DIV + 1);

    // The half-bit load is trimmed by the synchronizer, edge-detect and
    // expiry-cycle delays so that every sample lands near the bit centre and
    // rdy rises close to 9.5 bit times after the edge at the pin.
    localparam int HALF_TRIM = 3;
    localparam int HALF_LOAD = (BAUD_DIV / 2 > HALF_TRIM) ? (BAUD_DIV / 2 - HALF_TRIM) : 0;
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(HALF_LOAD);

    // The expiry cycle itself counts as one tick, so one bit period is the
    // reload value plus one.
    localparam logic [CNT_W-1:0] BIT_CNT = CNT_W'(BAUD_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    logic             rxMeta_q;
    logic             rxSync_q;
    logic             rxPrev_q;
    logic [1:0]       validPipe_q;
    logic             armed_q,  armed_d;
    state_t           state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [2:0]       bitIdx_q, bitIdx_d;
    logic [7:0]       shift_q,  shift_d;
    logic [7:0]       rxData_q, rxData_d;
    logic             rdy_q,    rdy_d;
    logic             ovr_q,    ovr_d;
    logic             frmErr_q, frmErr_d;

    logic             cntExpired;
    logic             startEdge;
    logic             deliver;

    // Two-flop synchronizer plus previous-sample register; validPipe marks when
    // the synchronizer holds real line samples rather than its reset ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxMeta_q    <= 1'b1;
            rxSync_q    <= 1'b1;
            rxPrev_q    <= 1'b1;
            validPipe_q <= 2'b00;
        end else begin
            rxMeta_q    <= RX;
            rxSync_q    <= rxMeta_q;
            rxPrev_q    <= rxSync_q;
            validPipe_q <= {validPipe_q[0], 1'b1};
        end
    end

    assign cntExpired = (cnt_q == '0);

    // A frame may only start from a genuine 1->0 edge seen after a genuine 1,
    // so a line held low out of reset or after a framing error cannot trigger.
    assign startEdge = armed_q && rxPrev_q && !rxSync_q;

    // Next-state logic: frame FSM, baud counter, shift register and handshake.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bitIdx_d = bitIdx_q;
        shift_d  = shift_q;
        rxData_d = rxData_q;
        rdy_d    = rdy_q;
        ovr_d    = ovr_q;
        armed_d  = armed_q;
        frmErr_d = 1'b0;
        deliver  = 1'b0;

        if (validPipe_q[1] && rxSync_q) begin
            armed_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (startEdge) begin
                    state_d = START;
                    cnt_d   = HALF_CNT;
                end
            end
            START: begin
                if (cntExpired) begin
                    if (!rxSync_q) begin
                        state_d  = DATA;
                        cnt_d    = BIT_CNT;
                        bitIdx_d = 3'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DATA: begin
                if (cntExpired) begin
                    shift_d[bitIdx_q] = rxSync_q;
                    cnt_d             = BIT_CNT;
                    if (bitIdx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bitIdx_d = bitIdx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            STOP: begin
                if (cntExpired) begin
                    state_d = IDLE;
                    if (rxSync_q) begin
                        deliver = 1'b1;
                    end else begin
                        frmErr_d = 1'b1;
                        armed_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (deliver) begin
            rxData_d = shift_q;
            rdy_d    = 1'b1;
            ovr_d    = ovr_q | (rdy_q & ~clr_rdy);
            if (clr_rdy) begin
                ovr_d = 1'b0;
            end
        end else if (clr_rdy && rdy_q) begin
            rdy_d = 1'b0;
            ovr_d = 1'b0;
        end
    end

    // State and datapath registers; reset wins over everything, even mid-frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bitIdx_q <= 3'd0;
            shift_q  <= 8'h00;
            rxData_q <= 8'h00;
            rdy_q    <= 1'b0;
            ovr_q    <= 1'b0;
            frmErr_q <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bitIdx_q <= bitIdx_d;
            shift_q  <= shift_d;
            rxData_q <= rxData_d;
            rdy_q    <= rdy_d;
            ovr_q    <= ovr_d;
            frmErr_q <= frmErr_d;
            armed_q  <= armed_d;
        end
    end

    assign rx_data = rxData_q;
    assign rdy     = rdy_q;
    assign ovr     = ovr_q;
    assign frm_err = frmErr_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb_uart_cmd_rx: directed frames into uart_cmd_rx; a scoreboard queue holds
// expected deliveries and a monitor compares them when the receiver presents a byte.
module tb_uart_cmd_rx;

    localparam int B       = 32;
    localparam int NOM_LAT = (19 * B) / 2;

    typedef struct {
        logic [7:0] data;
        logic       ovr;
        int         startCyc;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       RX;
    logic       clr_rdy;
    logic [7:0] rx_data;
    logic       rdy;
    logic       ovr;
    logic       frm_err;
    logic       busy;

    exp_t       expQ[$];
    exp_t       cur;
    int         checks;
    int         passes;
    int         cycleCount;
    int         frmErrCount;
    int         lastLatency;
    int         lat;
    int         startCyc;
    int         calLat;
    logic       prevRdy;
    logic [7:0] prevData;
    logic       prevOvr;
    logic       busySeen;
    logic       deliverEvt;

    uart_cmd_rx #(.BAUD_DIV(B)) dut (
        .clk     (clk),
        .rst     (rst),
        .RX      (RX),
        .clr_rdy (clr_rdy),
        .rx_data (rx_data),
        .rdy     (rdy),
        .ovr     (ovr),
        .frm_err (frm_err),
        .busy    (busy)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used to time frames and measure delivery latency.
    initial cycleCount = 0;
    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor: a delivery is rdy rising, or rx_data/ovr changing while rdy stays high.
    initial begin
        prevRdy     = 1'b0;
        prevData    = 8'h00;
        prevOvr     = 1'b0;
        frmErrCount = 0;
        lastLatency = 0;
    end
    always @(negedge clk) begin
        deliverEvt = (rdy === 1'b1) &&
                     ((prevRdy !== 1'b1) || (rx_data !== prevData) || (ovr === 1'b1 && prevOvr !== 1'b1));
        if (deliverEvt) begin
            if (expQ.size() == 0) begin
                checks++;
                $display("[TB] FAIL unexpected_byte: got %0h expected no delivery", rx_data);
            end else begin
                cur = expQ.pop_front();
                checkOutput("sb_data", {24'h0, rx_data}, {24'h0, cur.data});
                checkOutput("sb_ovr", {31'h0, ovr}, {31'h0, cur.ovr});
                lat         = cycleCount - cur.startCyc;
                lastLatency = lat;
                checks++;
                if (lat >= NOM_LAT - 2 && lat <= NOM_LAT + 2) begin
                    passes++;
                end else begin
                    $display("[TB] FAIL sb_latency: got %0d cycles expected %0d +-2", lat, NOM_LAT);
                end
            end
        end
        if (frm_err === 1'b1) frmErrCount++;
        prevRdy  = rdy;
        prevData = rx_data;
        prevOvr  = ovr;
    end

    task automatic expectByte(input logic [7:0] data, input logic expOvr);
        exp_t e;
        e.data     = data;
        e.ovr      = expOvr;
        e.startCyc = cycleCount;
        expQ.push_back(e);
    endtask

    // Drives one 8N1 frame, LSB first; called just after a falling clock edge.
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
        RX = 1'b0;
        repeat (B) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = data[i];
            repeat (B) @(negedge clk);
        end
        RX = stopBit;
        repeat (B) @(negedge clk);
    endtask

    task automatic watchBusy(input int cycles);
        busySeen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (busy !== 1'b0) busySeen = 1'b1;
        end
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 20 * B) begin
            @(negedge clk);
            n++;
        end
        if (expQ.size() != 0) begin
            checks++;
            $display("[TB] FAIL drain_timeout: got %0d pending expected 0", expQ.size());
            expQ.delete();
        end
    endtask

    task automatic pulseClr();
        clr_rdy = 1'b1;
        @(negedge clk);
        clr_rdy = 1'b0;
    endtask

    // Main directed sequence.
    initial begin
        checks  = 0;
        passes  = 0;
        RX      = 1'b0;
        rst     = 1'b1;
        clr_rdy = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_rx_data", {24'h0, rx_data}, 32'h00);
        checkOutput("reset_rdy", {31'h0, rdy}, 32'h0);
        checkOutput("reset_ovr", {31'h0, ovr}, 32'h0);
        checkOutput("reset_frm_err", {31'h0, frm_err}, 32'h0);
        checkOutput("reset_busy", {31'h0, busy}, 32'h0);

        // Release reset with the line low: nothing may start.
        rst = 1'b0;
        watchBusy(3 * B);
        checkOutput("no_start_low_after_reset", {31'h0, busySeen}, 32'h0);
        RX = 1'b1;
        repeat (B) @(negedge clk);

        // Single byte 'G', then acknowledge.
        expectByte(8'h47, 1'b0);
        applyStimulus(8'h47, 1'b1);
        waitDrain();
        checkOutput("g_rdy", {31'h0, rdy}, 32'h1);
        checkOutput("g_data", {24'h0, rx_data}, 32'h47);
        pulseClr();
        checkOutput("g_clr_rdy", {31'h0, rdy}, 32'h0);
        checkOutput("g_no_frm_err", frmErrCount, 32'd0);

        // Back-to-back bytes without acknowledge: overrun.
        expectByte(8'h53, 1'b0);
        applyStimulus(8'h53, 1'b1);
        expectByte(8'hA5, 1'b1);
        applyStimulus(8'hA5, 1'b1);
        waitDrain();
        checkOutput("ovr_data", {24'h0, rx_data}, 32'hA5);
        checkOutput("ovr_rdy", {31'h0, rdy}, 32'h1);
        checkOutput("ovr_flag", {31'h0, ovr}, 32'h1);
        pulseClr();
        checkOutput("ovr_clr_rdy", {31'h0, rdy}, 32'h0);
        checkOutput("ovr_clr_ovr", {31'h0, ovr}, 32'h0);

        // Short low glitch on an idle line.
        RX = 1'b0;
        repeat (10) @(negedge clk);
        RX = 1'b1;
        watchBusy(2 * B);
        checkOutput("glitch_busy_pulsed", {31'h0, busySeen}, 32'h1);
        checkOutput("glitch_busy_idle", {31'h0, busy}, 32'h0);
        checkOutput("glitch_rdy", {31'h0, rdy}, 32'h0);
        checkOutput("glitch_data", {24'h0, rx_data}, 32'hA5);
        checkOutput("glitch_frm_err", frmErrCount, 32'd0);

        // Bad stop bit, line held low, then a clean byte.
        applyStimulus(8'h3C, 1'b0);
        watchBusy(3 * B);
        checkOutput("frm_no_restart_low", {31'h0, busySeen}, 32'h0);
        checkOutput("frm_one_pulse", frmErrCount, 32'd1);
        checkOutput("frm_no_rdy", {31'h0, rdy}, 32'h0);
        checkOutput("frm_data_kept", {24'h0, rx_data}, 32'hA5);
        RX = 1'b1;
        repeat (B) @(negedge clk);
        expectByte(8'h12, 1'b0);
        applyStimulus(8'h12, 1'b1);
        waitDrain();
        checkOutput("after_frm_data", {24'h0, rx_data}, 32'h12);
        checkOutput("after_frm_rdy", {31'h0, rdy}, 32'h1);
        checkOutput("after_frm_pulses", frmErrCount, 32'd1);

        // Reset during data bit 4 of 0xFF, then a clean 0x81.
        startCyc = cycleCount;
        fork
            applyStimulus(8'hFF, 1'b1);
            begin
                while (cycleCount < startCyc + 5 * B + B / 2) @(negedge clk);
                checkOutput("midframe_busy", {31'h0, busy}, 32'h1);
                rst = 1'b1;
                @(negedge clk);
                checkOutput("midrst_rx_data", {24'h0, rx_data}, 32'h00);
                checkOutput("midrst_rdy", {31'h0, rdy}, 32'h0);
                checkOutput("midrst_ovr", {31'h0, ovr}, 32'h0);
                checkOutput("midrst_busy", {31'h0, busy}, 32'h0);
                checkOutput("midrst_frm_err", {31'h0, frm_err}, 32'h0);
                @(negedge clk);
                rst = 1'b0;
            end
        join
        repeat (B) @(negedge clk);
        expectByte(8'h81, 1'b0);
        applyStimulus(8'h81, 1'b1);
        waitDrain();
        checkOutput("post_rst_data", {24'h0, rx_data}, 32'h81);
        checkOutput("post_rst_rdy", {31'h0, rdy}, 32'h1);

        // Acknowledge on the very edge 0x66 completes, timed from the last delivery.
        calLat   = lastLatency;
        startCyc = cycleCount;
        expectByte(8'h66, 1'b0);
        fork
            applyStimulus(8'h66, 1'b1);
            begin
                while (cycleCount < startCyc + calLat - 1) @(negedge clk);
                pulseClr();
            end
        join
        waitDrain();
        checkOutput("same_edge_data", {24'h0, rx_data}, 32'h66);
        checkOutput("same_edge_rdy", {31'h0, rdy}, 32'h1);
        checkOutput("same_edge_ovr", {31'h0, ovr}, 32'h0);

        repeat (4) @(negedge clk);
        checkOutput("queue_empty", expQ.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
